midi_uart_fetch_arb: RTL and testbench
======================================

Name: midi_uart_fetch_arb

Overview:
- Multi-channel successor to the single-FIFO UART fetch stage in the bus-to-MIDI path.
- Takes N_CH independent byte FIFOs (one per virtual MIDI source) and round-robin arbitrates them onto one MIDI UART transmitter.
- Bounds each grant to MAX_BURST bytes so one channel cannot starve the others.
- Inserts the Active Sensing keep-alive byte (KEEPALIVE_BYTE), with lower priority than data.

Parameters:
- N_CH, 4, number of FIFO channels (1..16); CH_W = max(1, clog2(N_CH)) is derived.
- MAX_BURST, 3, maximum bytes sent per grant before re-arbitration (1..255).
- KEEPALIVE_BYTE, 8'hFE, byte emitted for keep-alive.
- KEEPALIVE_CYCLES, 1000000, idle-clock count before internal keep-alive (timer build only; must be >= 2).

Ports:
- midi_system_clock  in  1  sole clock.
- midi_rst_n  in  1  synchronous reset, active-low.
- midi_clk_locked  in  1  clock-locked status; low forces idle.
- keep_alive  in  1  one-cycle keep-alive request (used only without MIDI_FETCH_TIMER_EN).
- fifo_out  in  N_CH*8  channel c data at [8c+7:8c], first-word-fall-through.
- fifo_valid  in  N_CH  per-channel data valid.
- fifo_almost_empty  in  N_CH  per-channel: one or zero words left.
- fifo_rd_rst_busy  in  N_CH  per-channel FIFO reset in progress.
- fifo_rd  out  N_CH  per-channel read strobe.
- uart_done  in  1  one-cycle pulse: current byte consumed by UART.
- uart_idle  in  1  UART transmitter idle.
- uart_valid  out  1  byte presented to UART.
- uart_data  out  8  byte to UART.
- cur_ch  out  CH_W  currently or last granted channel.

Behaviour:
- Reset (midi_rst_n==0 at clock edge):
  - state=S_IDLE; last_grant=N_CH-1, so channel 0 wins first; burst_cnt=0; ka_pending=0; timer=0.
  - Outputs: uart_valid=0, uart_data=8'h00, fifo_rd=0, cur_ch=0.
- Qualifier: eligible[c] = fifo_valid[c] & ~fifo_rd_rst_busy[c].
- midi_clk_locked==0 has the same effect as reset on state, burst_cnt, ka_pending and timer. last_grant is kept.
- States: S_IDLE, S_KEEP_ALIVE, S_DATA.
- S_IDLE:
  - If any eligible channel: grant the first eligible channel searching from last_grant+1 modulo N_CH. Then cur_ch<=grant, last_grant<=grant, burst_cnt<=0, go to S_DATA.
  - Else if ka_pending and uart_idle: go to S_KEEP_ALIVE.
  - Else stay.
  - Decision takes 1 cycle; uart_valid rises the cycle after the state change.
- S_KEEP_ALIVE:
  - uart_valid=1, uart_data=KEEPALIVE_BYTE.
  - On uart_done: ka_pending<=0, go to S_IDLE.
- S_DATA, granted channel g:
  - uart_valid=fifo_valid[g], uart_data=fifo_out[g], fifo_rd[g]=uart_done & fifo_valid[g]. All other fifo_rd bits are 0.
  - On uart_done: burst_cnt++.
  - Exit to S_IDLE on uart_done when fifo_almost_empty[g] is 1, or when burst_cnt==MAX_BURST-1.
  - If fifo_rd_rst_busy[g] rises: go to S_IDLE next cycle, no fifo_rd, burst aborted.
- Outputs in S_IDLE: uart_valid=0, uart_data=8'h00, fifo_rd=0.
- Simultaneous events:
  - Data always beats a pending keep-alive.
  - A keep-alive request arriving while in S_DATA sets ka_pending, which is served after the burst only if no channel is eligible.
  - keep_alive and uart_done in the same cycle: both take effect.
- N_CH==1: arbitration degenerates; the channel is re-granted after each burst; cur_ch stays 0.
- fifo_rd is combinational from uart_done; at most one fifo_rd bit is high per cycle.

Optional Feature:
- Macro MIDI_FETCH_TIMER_EN.
- Defined:
  - Internal timer counts clocks while the state is not S_DATA or S_KEEP_ALIVE.
  - Timer clears on any uart_done and on entry to S_DATA.
  - When the timer reaches KEEPALIVE_CYCLES-1: ka_pending<=1 and timer<=0.
  - keep_alive input is ignored.
- Undefined:
  - No timer; keep_alive==1 sets ka_pending.
  - Repeated pulses while pending are merged.

Test Plan:
- Ch0 holds 5 bytes 90 3C 7F 80 3C, MAX_BURST=3, others empty -> bytes 90 3C 7F from ch0, return to S_IDLE, then ch0 re-granted for 80 3C. Exactly 5 fifo_rd[0] pulses.
- Ch0 holds A1..A4, ch2 holds C1..C4, MAX_BURST=3 -> UART order A1 A2 A3 C1 C2 C3 A4 C4; cur_ch sequence 0,2,0,2.
- Without timer: keep_alive pulse in S_IDLE with FIFOs empty -> uart_data=FE, uart_valid=1 until uart_done, then no fifo_rd. A keep_alive pulse during a ch1 burst -> FE sent only after the burst ends and ch1 is empty.
- With timer, KEEPALIVE_CYCLES=100, no data -> FE presented every ~100 clocks after each uart_done. Data arriving at cycle 50 -> no FE until 100 idle cycles after the last data byte.
- fifo_rd_rst_busy[1] asserted mid-burst on ch1 -> S_IDLE next cycle, no further fifo_rd[1], ch1 skipped by arbitration while busy.
- midi_rst_n=0 or midi_clk_locked=0 during S_DATA -> next cycle uart_valid=0, fifo_rd=0, state S_IDLE, ka_pending cleared.

Source files
------------

// File: rtl/midi_uart_fetch_arb.sv
// Round-robin fetch stage: N_CH first-word-fall-through byte FIFOs onto one MIDI UART,
// bounded bursts, Active Sensing keep-alive. Define MIDI_FETCH_TIMER_EN for the internal idle timer.
module midi_uart_fetch_arb #(
    parameter int          N_CH             = 4,
    parameter int          MAX_BURST        = 3,
    parameter logic [7:0]  KEEPALIVE_BYTE   = 8'hFE,
    parameter int          KEEPALIVE_CYCLES = 1000000,
    localparam int         CH_W             = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                midi_system_clock,
    input  logic                midi_rst_n,
    input  logic                midi_clk_locked,
    input  logic                keep_alive,
    input  logic [N_CH*8-1:0]   fifo_out,
    input  logic [N_CH-1:0]     fifo_valid,
    input  logic [N_CH-1:0]     fifo_almost_empty,
    input  logic [N_CH-1:0]     fifo_rd_rst_busy,
    output logic [N_CH-1:0]     fifo_rd,
    input  logic                uart_done,
    input  logic                uart_idle,
    output logic                uart_valid,
    output logic [7:0]          uart_data,
    output logic [CH_W-1:0]     cur_ch
);

    localparam logic [1:0]      S_IDLE       = 2'd0;
    localparam logic [1:0]      S_KEEP_ALIVE = 2'd1;
    localparam logic [1:0]      S_DATA       = 2'd2;
    localparam logic [CH_W-1:0] LAST_CH      = CH_W'(N_CH - 1);
    localparam logic [7:0]      BURST_LAST   = 8'(MAX_BURST - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [CH_W-1:0] r_last_grant;
    logic [CH_W-1:0] r_cur_ch;
    logic [CH_W-1:0] w_grant;
    logic [CH_W-1:0] w_idx;
    logic [7:0]      r_burst_cnt;
    logic [7:0]      w_burst_nxt;
    logic            r_ka_pending;
    logic            w_ka_set;
    logic            w_ka_clr;
    logic            w_found;
    logic            w_load_grant;
    logic [N_CH-1:0] w_elig;
    logic            w_g_valid;
    logic            w_g_ae;
    logic            w_g_busy;
    logic [7:0]      w_g_data;

    assign w_elig = fifo_valid & ~fifo_rd_rst_busy;
    assign cur_ch = r_cur_ch;

    // Round-robin search starting one past the last granted channel
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = CH_W'((int'(r_last_grant) + i) % N_CH);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Views of the currently granted channel
    always_comb begin
        w_g_valid = fifo_valid[r_cur_ch];
        w_g_ae    = fifo_almost_empty[r_cur_ch];
        w_g_busy  = fifo_rd_rst_busy[r_cur_ch];
        w_g_data  = fifo_out[{r_cur_ch, 3'b000} +: 8];
    end

    // Next-state, burst counter and grant-load decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_burst_nxt  = r_burst_cnt;
        w_load_grant = 1'b0;
        w_ka_clr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_DATA;
                    w_burst_nxt  = 8'd0;
                    w_load_grant = 1'b1;
                end else if (r_ka_pending && uart_idle) begin
                    w_state_nxt = S_KEEP_ALIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_KEEP_ALIVE: begin
                if (uart_done) begin
                    w_state_nxt = S_IDLE;
                    w_ka_clr    = 1'b1;
                end else begin
                    w_state_nxt = S_KEEP_ALIVE;
                end
            end
            S_DATA: begin
                // A FIFO entering reset aborts the burst without a read
                if (w_g_busy) begin
                    w_state_nxt = S_IDLE;
                    w_burst_nxt = 8'd0;
                end else if (uart_done) begin
                    w_burst_nxt = r_burst_cnt + 8'd1;
                    if (w_g_ae || (r_burst_cnt == BURST_LAST)) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_burst_nxt = 8'd0;
            end
        endcase
    end

`ifdef MIDI_FETCH_TIMER_EN
    localparam int              TMR_W    = $clog2(KEEPALIVE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(KEEPALIVE_CYCLES - 1);

    logic [TMR_W-1:0] r_timer;
    logic             w_tmr_clr;
    logic             w_tmr_hit;
    logic             w_keep_alive_unused;

    assign w_keep_alive_unused = keep_alive;
    assign w_tmr_clr = uart_done | ((r_state == S_IDLE) & w_found);
    assign w_tmr_hit = (r_state == S_IDLE) & ~w_tmr_clr & (r_timer == TMR_LAST);
    assign w_ka_set  = w_tmr_hit;

    // Idle-time counter that raises a keep-alive request when it expires
    always_ff @(posedge midi_system_clock) begin
        if (!midi_rst_n) begin
            r_timer <= '0;
        end else if (!midi_clk_locked) begin
            r_timer <= '0;
        end else if (w_tmr_clr || w_tmr_hit) begin
            r_timer <= '0;
        end else if (r_state == S_IDLE) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= r_timer;
        end
    end
`else
    assign w_ka_set = keep_alive;
`endif

    // Arbiter state; losing clock lock idles the block but keeps round-robin position
    always_ff @(posedge midi_system_clock) begin
        if (!midi_rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= LAST_CH;
            r_cur_ch     <= '0;
            r_burst_cnt  <= 8'd0;
            r_ka_pending <= 1'b0;
        end else if (!midi_clk_locked) begin
            r_state      <= S_IDLE;
            r_burst_cnt  <= 8'd0;
            r_ka_pending <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_ka_pending <= w_ka_set | (r_ka_pending & ~w_ka_clr);
            if (w_load_grant) begin
                r_cur_ch     <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    // UART presentation and FIFO read strobe
    always_comb begin
        uart_valid = 1'b0;
        uart_data  = 8'h00;
        fifo_rd    = '0;
        case (r_state)
            S_KEEP_ALIVE: begin
                uart_valid = 1'b1;
                uart_data  = KEEPALIVE_BYTE;
            end
            S_DATA: begin
                uart_valid        = w_g_valid;
                uart_data         = w_g_data;
                fifo_rd[r_cur_ch] = uart_done & w_g_valid & ~w_g_busy;
            end
            default: begin
                uart_valid = 1'b0;
                uart_data  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_midi_uart_fetch_arb.sv
// Self-checking bench for midi_uart_fetch_arb (default build, MAX_BURST=3, N_CH=4).
module tb_midi_uart_fetch_arb;

    localparam int N_CH      = 4;
    localparam int MAX_BURST = 3;

    logic              midi_system_clock = 1'b0;
    logic              midi_rst_n = 1'b0;
    logic              midi_clk_locked = 1'b1;
    logic              keep_alive = 1'b0;
    logic [N_CH*8-1:0] fifo_out = '0;
    logic [N_CH-1:0]   fifo_valid = '0;
    logic [N_CH-1:0]   fifo_almost_empty = '1;
    logic [N_CH-1:0]   fifo_rd_rst_busy = '0;
    logic [N_CH-1:0]   fifo_rd;
    logic              uart_done = 1'b0;
    logic              uart_idle = 1'b1;
    logic              uart_valid;
    logic [7:0]        uart_data;
    logic [1:0]        cur_ch;

    midi_uart_fetch_arb #(.N_CH(N_CH), .MAX_BURST(MAX_BURST), .KEEPALIVE_BYTE(8'hFE)) dut (
        .midi_system_clock (midi_system_clock),
        .midi_rst_n        (midi_rst_n),
        .midi_clk_locked   (midi_clk_locked),
        .keep_alive        (keep_alive),
        .fifo_out          (fifo_out),
        .fifo_valid        (fifo_valid),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_rst_busy  (fifo_rd_rst_busy),
        .fifo_rd           (fifo_rd),
        .uart_done         (uart_done),
        .uart_idle         (uart_idle),
        .uart_valid        (uart_valid),
        .uart_data         (uart_data),
        .cur_ch            (cur_ch)
    );

    always #5 midi_system_clock = ~midi_system_clock;

    typedef struct packed {
        logic [15:0] lens;
        logic [7:0]  ka_at;
        logic [3:0]  n_exp;
        logic [3:0]  n_rd;
        logic [63:0] exp;
    } vec_t;

    vec_t        tv [7];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  mem [N_CH][16];
    int          hd [N_CH];
    int          tl [N_CH];
    logic [7:0]  exp_b [$];
    logic [7:0]  got_b [$];
    logic [1:0]  got_c [$];
    int          rd_cnt;
    bit          multi_rd;
    int          lat;
    int          wcnt;
    logic        n_rst = 1'b1;
    logic        n_locked = 1'b1;
    logic [N_CH-1:0] n_busy = '0;
    int          rlen [N_CH];
    int          rtot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        for (int c = 0; c < N_CH; c++) begin
            hd[c] = 0;
            tl[c] = 0;
        end
    endtask

    task automatic push(input int c, input logic [7:0] b);
        mem[c][tl[c]] = b;
        tl[c]++;
    endtask

    task automatic drive_fifo();
        for (int c = 0; c < N_CH; c++) begin
            int n;
            n = tl[c] - hd[c];
            fifo_valid[c]        = (n > 0);
            fifo_almost_empty[c] = (n <= 1);
            fifo_out[8*c +: 8]   = (n > 0) ? mem[c][hd[c]] : 8'h00;
        end
    endtask

    task automatic apply_inputs(input bit k);
        midi_rst_n       = n_rst;
        midi_clk_locked  = n_locked;
        fifo_rd_rst_busy = n_busy;
        keep_alive       = k;
        drive_fifo();
    endtask

    task automatic pop_rd();
        for (int c = 0; c < N_CH; c++) begin
            if (fifo_rd[c] && hd[c] < tl[c]) hd[c]++;
        end
    endtask

    // One hand-driven cycle; outputs are stable for checking on return
    task automatic cyc(input logic d, input bit k);
        @(negedge midi_system_clock);
        apply_inputs(k);
        uart_done = d;
        #1;
        pop_rd();
    endtask

    // One cycle with the UART model consuming presented bytes after a random latency
    task automatic stream_cyc(input bit k);
        @(negedge midi_system_clock);
        apply_inputs(k);
        uart_done = 1'b0;
        #1;
        if (uart_valid && wcnt >= lat) uart_done = 1'b1;
        #1;
        if (uart_valid && uart_done) begin
            got_b.push_back(uart_data);
            got_c.push_back(cur_ch);
        end
        if ($countones(fifo_rd) > 1) multi_rd = 1'b1;
        rd_cnt += $countones(fifo_rd);
        pop_rd();
        if (uart_done) begin
            wcnt = 0;
            lat  = $urandom_range(0, 3);
        end else if (uart_valid) begin
            wcnt++;
        end
    endtask

    task automatic run_stream(input int ka1, input int ka2, input int n_exp);
        got_b.delete();
        got_c.delete();
        rd_cnt   = 0;
        multi_rd = 1'b0;
        wcnt     = 0;
        lat      = $urandom_range(0, 3);
        for (int i = 0; i < 2000 && got_b.size() < n_exp; i++) stream_cyc(i == ka1 || i == ka2);
        for (int i = 0; i < 12; i++) stream_cyc(1'b0);
        uart_done = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n_rd);
        check($sformatf("%s_len", tag), got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
            if (exp_b[i] != 8'hFE) check($sformatf("%s_ch%0d", tag, i), got_c[i], exp_b[i][7:4] - 4'hA);
        end
        check($sformatf("%s_rdcnt", tag), rd_cnt, n_rd);
        check($sformatf("%s_onehot", tag), multi_rd, 0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("rst_valid", uart_valid, 0);
        check("rst_data", uart_data, 8'h00);
        check("rst_rd", fifo_rd, 0);
        check("rst_cur", cur_ch, 0);
        n_rst = 1'b1;
    endtask

    // Expected byte stream from the arbitration rules: round robin, bursts of at most MAX_BURST
    task automatic build_expect();
        int rem [N_CH];
        int last;
        int take;
        bit any;
        exp_b.delete();
        for (int c = 0; c < N_CH; c++) rem[c] = rlen[c];
        last = N_CH - 1;
        any  = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 1; i <= N_CH; i++) begin
                int c;
                c = (last + i) % N_CH;
                if (!any && rem[c] > 0) begin
                    any  = 1'b1;
                    take = (rem[c] < MAX_BURST) ? rem[c] : MAX_BURST;
                    for (int j = 0; j < take; j++) begin
                        exp_b.push_back(8'((10 + c) * 16 + rlen[c] - rem[c] + 1));
                        rem[c]--;
                    end
                    last = c;
                end
            end
        end
        exp_b.push_back(8'hFE);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // lens nibble c = byte count of channel c; bytes of channel c are {A+c, index}
        tv[0] = {16'h0005, 8'hFF, 4'd5, 4'd5, 64'h000000A5A4A3A2A1};
        tv[1] = {16'h0404, 8'hFF, 4'd8, 4'd8, 64'hC4A4C3C2C1A3A2A1};
        tv[2] = {16'h1111, 8'hFF, 4'd4, 4'd4, 64'h00000000D1C1B1A1};
        tv[3] = {16'h1042, 8'hFF, 4'd7, 4'd7, 64'h00B4D1B3B2B1A2A1};
        tv[4] = {16'h0040, 8'd3,  4'd5, 4'd4, 64'h000000FEB4B3B2B1};
        tv[5] = {16'h0000, 8'd1,  4'd1, 4'd0, 64'h00000000000000FE};
        tv[6] = {16'h2000, 8'd1,  4'd3, 4'd2, 64'h0000000000FED2D1};

        for (int t = 0; t < 7; t++) begin
            clear_q();
            for (int c = 0; c < N_CH; c++) begin
                for (int k = 0; k < int'(tv[t].lens[4*c +: 4]); k++) push(c, 8'((10 + c) * 16 + k + 1));
            end
            do_reset();
            exp_b.delete();
            for (int i = 0; i < int'(tv[t].n_exp); i++) exp_b.push_back(tv[t].exp[8*i +: 8]);
            run_stream((tv[t].ka_at == 8'hFF) ? -1 : int'(tv[t].ka_at), -1, exp_b.size());
            check_stream($sformatf("vec%0d", t), int'(tv[t].n_rd));
        end

        // FIFO reset mid-burst on ch1: abort, skip ch1 while busy, resume afterwards
        clear_q();
        for (int k = 1; k <= 4; k++) push(1, 8'(8'hB0 + k));
        push(2, 8'hC1);
        push(2, 8'hC2);
        do_reset();
        cyc(1'b0, 1'b0);
        check("bsy_idle_valid", uart_valid, 0);
        cyc(1'b0, 1'b0);
        check("bsy_ch1", cur_ch, 1);
        check("bsy_b1", uart_data, 8'hB1);
        cyc(1'b1, 1'b0);
        check("bsy_rd_b1", fifo_rd, 4'b0010);
        n_busy = 4'b0010;
        cyc(1'b1, 1'b0);
        check("bsy_no_rd", fifo_rd, 0);
        cyc(1'b0, 1'b0);
        check("bsy_idle2_valid", uart_valid, 0);
        check("bsy_idle2_rd", fifo_rd, 0);
        cyc(1'b0, 1'b0);
        check("bsy_ch2", cur_ch, 2);
        check("bsy_c1", uart_data, 8'hC1);
        cyc(1'b1, 1'b0);
        check("bsy_rd_c1", fifo_rd, 4'b0100);
        cyc(1'b1, 1'b0);
        check("bsy_c2", uart_data, 8'hC2);
        check("bsy_rd_c2", fifo_rd, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            check("bsy_skip_valid", uart_valid, 0);
        end
        n_busy = 4'b0000;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("bsy_resume_ch", cur_ch, 1);
        check("bsy_resume_b2", uart_data, 8'hB2);

        // Clock lock lost during a burst with keep-alive pending
        clear_q();
        for (int k = 1; k <= 3; k++) push(0, 8'(8'hA0 + k));
        do_reset();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("lck_a1", uart_data, 8'hA1);
        check("lck_a1_valid", uart_valid, 1);
        n_locked = 1'b0;
        cyc(1'b0, 1'b0);
        n_locked = 1'b1;
        cyc(1'b1, 1'b0);
        check("lck_valid", uart_valid, 0);
        check("lck_rd", fifo_rd, 0);
        exp_b.delete();
        for (int k = 1; k <= 3; k++) exp_b.push_back(8'(8'hA0 + k));
        run_stream(-1, -1, 3);
        check_stream("lck", 3);

        // Reset during a burst
        clear_q();
        push(2, 8'hC1);
        push(2, 8'hC2);
        do_reset();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("rdat_ch2", cur_ch, 2);
        n_rst = 1'b0;
        cyc(1'b0, 1'b0);
        n_rst = 1'b1;
        cyc(1'b1, 1'b0);
        check("rdat_valid", uart_valid, 0);
        check("rdat_rd", fifo_rd, 0);
        check("rdat_cur", cur_ch, 0);

        // Randomized channel loads with merged keep-alive pulses against the rule model
        for (int r = 0; r < 6; r++) begin
            clear_q();
            rtot = 0;
            for (int c = 0; c < N_CH; c++) rlen[c] = $urandom_range(0, 6);
            for (int c = 0; c < N_CH; c++) rtot += rlen[c];
            if (rtot < 2) rlen[$urandom_range(0, 3)] = 2;
            rtot = 0;
            for (int c = 0; c < N_CH; c++) begin
                rtot += rlen[c];
                for (int k = 0; k < rlen[c]; k++) push(c, 8'((10 + c) * 16 + k + 1));
            end
            build_expect();
            do_reset();
            run_stream($urandom_range(0, 3), $urandom_range(0, 3), exp_b.size());
            check_stream($sformatf("rnd%0d", r), rtot);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
